// File: rtl/axi_slave_mem.sv
// ============================================================================
// Module   : axi_slave_mem
// Purpose  : AXI4-style memory slave. It consumes incrementing bursts of
//            1..256 beats over a word array. The write path (AW/W/B) and the
//            read path (AR/R) are independent FSMs that may run concurrently.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            AW*/W*/B*             - write address, data and response channels
//            AR*/R*                - read address and data channels
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // write address channel
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    // write data channel
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    // write response channel
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    // read address channel
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    // read data channel
    output logic [DATA_W-1:0] RDATA,
    output logic              RLAST,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY
);

    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Word array: deliberately not reset so contents survive rst_n.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Address decode for both channels
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_aw_idx;
    logic [IDX_W-1:0] w_ar_idx;
    logic             w_aw_range_err;
    logic             w_ar_range_err;
    logic             w_unused_addr;

    assign w_aw_idx       = AWADDR[IDX_W+OFF-1:OFF];
    assign w_ar_idx       = ARADDR[IDX_W+OFF-1:OFF];
    // Any address bit above the array window marks the whole burst bad.
    assign w_aw_range_err = (AWADDR >> (IDX_W + OFF)) != '0;
    assign w_ar_range_err = (ARADDR >> (IDX_W + OFF)) != '0;
    // Byte-lane offset bits carry no meaning for a word-wide array.
    assign w_unused_addr  = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    w_state_t         w_state_q, w_state_d;
    logic             awready_q, awready_d;
    logic             wready_q,  wready_d;
    logic             bvalid_q,  bvalid_d;
    logic [1:0]       bresp_q,   bresp_d;
    logic [IDX_W-1:0] widx_q,    widx_d;
    logic [7:0]       wlen_q,    wlen_d;
    logic [7:0]       wcnt_q,    wcnt_d;
    logic             werr_q,    werr_d;
    logic             w_mem_we;
    logic             w_wbeat_last;
    logic             w_wlast_err;

    // Burst length comes from AWLEN alone; WLAST is only cross-checked.
    assign w_wbeat_last = (wcnt_q == wlen_q);
    assign w_wlast_err  = (WLAST != w_wbeat_last);

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        w_mem_we  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    widx_d    = w_aw_idx;
                    wlen_d    = AWLEN;
                    wcnt_d    = 8'd0;
                    werr_d    = w_aw_range_err;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    // A beat that itself carries a WLAST mismatch is still
                    // stored; only errors known before the beat block it.
                    w_mem_we = !werr_q;
                    widx_d   = widx_q + IDX_W'(1);
                    wcnt_d   = wcnt_q + 8'd1;
                    if (w_wlast_err) begin
                        werr_d = 1'b1;
                    end
                    if (w_wbeat_last) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (werr_q || w_wlast_err) ? c_resp_slverr : c_resp_okay;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = c_resp_okay;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    r_state_t          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic              rlast_q,   rlast_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [IDX_W-1:0]  ridx_q,    ridx_d;
    logic [7:0]        rlen_q,    rlen_d;
    logic [7:0]        rcnt_q,    rcnt_d;
    logic              rerr_q,    rerr_d;

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    // First beat is fetched on the AR edge itself; ridx then
                    // points at the word for the following beat.
                    rdata_d   = w_ar_range_err ? '0 : mem[w_ar_idx];
                    rresp_d   = w_ar_range_err ? c_resp_slverr : c_resp_okay;
                    rlast_d   = (ARLEN == 8'd0);
                    rvalid_d  = 1'b1;
                    rerr_d    = w_ar_range_err;
                    ridx_d    = w_ar_idx + IDX_W'(1);
                    rlen_d    = ARLEN;
                    rcnt_d    = 8'd0;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = c_resp_okay;
                        rdata_d   = '0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d = rerr_q ? '0 : mem[ridx_q];
                        ridx_d  = ridx_q + IDX_W'(1);
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            widx_q    <= '0;
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rerr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
        end
    end

    // Array write; a beat landing on a reset edge is dropped. The read path
    // samples the array combinationally, so a same-edge read sees old data.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            mem[widx_q] <= WDATA;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
// ============================================================================
// Module   : tb_axi_slave_mem
// Purpose  : Self-checking directed bench for axi_slave_mem.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_slave_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd_data [0:7];
    logic        rd_last [0:7];
    logic [1:0]  rd_resp [0:7];
    logic [1:0]  bresp_seen;

    axi_slave_mem #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (256)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RLAST   (RLAST),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP}, 64'd0);
        check({tag, "_rdata"}, RDATA, 64'd0);
    endtask

    task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len);
        int t = 0;
        AWADDR  = addr;
        AWLEN   = len;
        AWVALID = 1'b1;
        while (!AWREADY && t < 50) begin tick(); t++; end
        check("awready_wait", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic last);
        int t = 0;
        WDATA  = data;
        WLAST  = last;
        WVALID = 1'b1;
        while (!WREADY && t < 50) begin tick(); t++; end
        check("wready_wait", WREADY, 1);
        tick();
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_hs(input int delay, output logic [1:0] resp);
        int t = 0;
        while (!BVALID && t < 50) begin tick(); t++; end
        check("bvalid_wait", BVALID, 1);
        resp = BRESP;
        for (int i = 0; i < delay; i++) begin
            tick();
            check("bvalid_hold", BVALID, 1);
            check("awready_low_in_b", AWREADY, 0);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_clear", BVALID, 0);
        check("awready_after_b", AWREADY, 1);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [31:0] dbase, input int wlast_at,
                               input int bdelay, output logic [1:0] resp);
        aw_hs(addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            w_beat(dbase + 32'(i), i == wlast_at);
        end
        check("wready_drop", WREADY, 0);
        b_hs(bdelay, resp);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input int stall);
        int t = 0;
        ARADDR  = addr;
        ARLEN   = len;
        ARVALID = 1'b1;
        while (!ARREADY && t < 50) begin tick(); t++; end
        check("arready_wait", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
        check("rvalid_first_beat", RVALID, 1);
        RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!RVALID && t < 50) begin tick(); t++; end
            check("rvalid_wait", RVALID, 1);
            rd_data[i] = RDATA;
            rd_last[i] = RLAST;
            rd_resp[i] = RRESP;
            if (i == 0 && stall > 0) begin
                RREADY = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    tick();
                    check("rdata_hold", RDATA, rd_data[0]);
                    check("rvalid_hold", RVALID, 1);
                end
                RREADY = 1'b1;
            end
            tick();
        end
        RREADY = 1'b0;
        check("rvalid_end", RVALID, 0);
        check("arready_end", ARREADY, 1);
    endtask

    task automatic check_read(input string tag, input logic [7:0] len, input logic [31:0] base,
                              input logic [31:0] step, input logic [1:0] resp);
        for (int i = 0; i <= int'(len); i++) begin
            check({tag, "_data"}, rd_data[i], base + step * 32'(i));
            check({tag, "_last"}, rd_last[i], i == int'(len));
            check({tag, "_resp"}, rd_resp[i], resp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        AWADDR  = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA   = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = '0; ARLEN = '0; ARVALID = 1'b0;
        RREADY  = 1'b0;

        // Reset state
        repeat (2) tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        check("awready_idle", AWREADY, 1);
        check("arready_idle", ARREADY, 1);

        // 1. Four-beat burst at 0x10
        write_burst(32'h10, 8'd3, 32'hA0, 3, 0, bresp_seen);
        check("t1_bresp", bresp_seen, 2'b00);
        read_burst(32'h10, 8'd3, 0);
        check_read("t1_read", 8'd3, 32'hA0, 32'd1, 2'b00);

        // 2. Top word and index wrap
        write_burst(32'h3FC, 8'd0, 32'h55, 0, 0, bresp_seen);
        check("t2_bresp", bresp_seen, 2'b00);
        read_burst(32'h3FC, 8'd0, 0);
        check_read("t2_single", 8'd0, 32'h55, 32'd1, 2'b00);
        write_burst(32'h3FC, 8'd2, 32'hB0, 2, 0, bresp_seen);
        check("t2_wrap_bresp", bresp_seen, 2'b00);
        read_burst(32'h000, 8'd1, 0);
        check_read("t2_wrap_idx0", 8'd1, 32'hB1, 32'd1, 2'b00);
        read_burst(32'h3FC, 8'd2, 0);
        check_read("t2_wrap_read", 8'd2, 32'hB0, 32'd1, 2'b00);

        // 3. Out-of-range address (would alias idx 0 if not rejected)
        write_burst(32'h400, 8'd0, 32'hDEAD, 0, 0, bresp_seen);
        check("t3_bresp", bresp_seen, 2'b10);
        read_burst(32'h000, 8'd0, 0);
        check_read("t3_mem_kept", 8'd0, 32'hB1, 32'd1, 2'b00);
        read_burst(32'h400, 8'd1, 0);
        check_read("t3_err_read", 8'd1, 32'h0, 32'd0, 2'b10);

        // 4. Early WLAST: all four beats still taken, SLVERR
        write_burst(32'h40, 8'd3, 32'hD0, 1, 0, bresp_seen);
        check("t4_bresp", bresp_seen, 2'b10);

        // 5. Back-pressure on R and B
        read_burst(32'h10, 8'd3, 3);
        check_read("t5_stall_read", 8'd3, 32'hA0, 32'd1, 2'b00);
        write_burst(32'h80, 8'd0, 32'hE0, 0, 5, bresp_seen);
        check("t5_bresp", bresp_seen, 2'b00);

        // 6. Reset after beat 1 of 4
        aw_hs(32'h100, 8'd3);
        w_beat(32'hC0, 1'b0);
        w_beat(32'hC1, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all_zero("t6_midburst_reset");
        rst_n = 1'b1;
        tick();
        read_burst(32'h100, 8'd1, 0);
        check_read("t6_kept_beats", 8'd1, 32'hC0, 32'd1, 2'b00);

        // Same-edge read and write of idx 128: read returns the old word
        write_burst(32'h200, 8'd0, 32'h1111, 0, 0, bresp_seen);
        aw_hs(32'h200, 8'd0);
        ARADDR  = 32'h200;
        ARLEN   = 8'd0;
        ARVALID = 1'b1;
        WDATA   = 32'h2222;
        WLAST   = 1'b1;
        WVALID  = 1'b1;
        check("rbw_both_ready", {ARREADY, WREADY}, 2'b11);
        tick();
        ARVALID = 1'b0;
        WVALID  = 1'b0;
        WLAST   = 1'b0;
        check("rbw_old_data", RDATA, 32'h1111);
        check("rbw_rvalid", RVALID, 1);
        check("rbw_bvalid", BVALID, 1);
        RREADY = 1'b1;
        BREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        BREADY = 1'b0;
        read_burst(32'h200, 8'd0, 0);
        check_read("rbw_new_data", 8'd0, 32'h2222, 32'd1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
